// File: rtl/slv_guard_mc_if.sv
// rtl/slv_guard_mc_if.sv - per-channel request/response handshake bundle for slv_guard_mc
interface slv_guard_mc_if #(
  parameter int NumCh = 2
);
  logic [NumCh-1:0] req_valid_i;
  logic [NumCh-1:0] req_ready_o;
  logic [NumCh-1:0] req_valid_o;
  logic [NumCh-1:0] req_ready_i;
  logic [NumCh-1:0] rsp_valid_i;
  logic [NumCh-1:0] rsp_ready_i;
  logic [NumCh-1:0] rsp_last_i;

  modport slave (
    input  req_valid_i, req_ready_i, rsp_valid_i, rsp_ready_i, rsp_last_i,
    output req_ready_o, req_valid_o
  );

  modport master (
    output req_valid_i, req_ready_i, rsp_valid_i, rsp_ready_i, rsp_last_i,
    input  req_ready_o, req_valid_o
  );
endinterface

// File: rtl/slv_guard_mc.sv
// rtl/slv_guard_mc.sv - multi-channel transaction timeout guard with reset-request handshake
// Optional per-channel retire-latency maximum: define SLV_GUARD_MC_STAT_EN.
module slv_guard_mc #(
  parameter int NumCh        = 2,
  parameter int MaxTxns      = 8,
  parameter int CntWidth     = 10,
  parameter int PrescalerDiv = 1,
  parameter int ResetOnFault = 1,
  localparam int OutW        = $clog2(MaxTxns + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      guard_ena_i,
  slv_guard_mc_if.slave             bus,
  input  logic [NumCh*CntWidth-1:0] budget_i,
  input  logic                      clear_i,
  output logic                      irq_o,
  output logic [NumCh-1:0]          fault_o,
  output logic [NumCh*OutW-1:0]     outstanding_o,
  output logic                      rst_req_o,
  input  logic                      rst_stat_i,
  output logic [NumCh*CntWidth-1:0] max_lat_o
);
  typedef enum logic [1:0] {CH_IDLE, CH_BUSY, CH_FAULT} ch_state_e;
  typedef enum logic [1:0] {RS_RUN, RS_REQ, RS_WAIT} rs_state_e;

  localparam int PW = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
  localparam logic [CntWidth-1:0] TimerMax = '1;

  ch_state_e           state_q [NumCh];
  ch_state_e           state_d [NumCh];
  logic [OutW-1:0]     count_q [NumCh];
  logic [OutW-1:0]     count_d [NumCh];
  logic [CntWidth-1:0] timer_q [NumCh];
  logic [CntWidth-1:0] timer_d [NumCh];
  rs_state_e           rs_q, rs_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                irq_q, irq_d;
  logic                rst_req_q, rst_req_d;
  logic                tick, rs_done, clear_ok, any_fault;
  logic [NumCh-1:0]    gate, accept, retire, timeout;

  // With PrescalerDiv=1 the counter never leaves 0, so tick is held high.
  always_comb begin
    tick    = (presc_q == PW'(PrescalerDiv - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    for (int c = 0; c < NumCh; c++) begin
      gate[c]    = (state_q[c] == CH_FAULT) || (count_q[c] == OutW'(MaxTxns));
      accept[c]  = bus.req_valid_i[c] && bus.req_ready_i[c] && !gate[c];
      retire[c]  = bus.rsp_valid_i[c] && bus.rsp_ready_i[c] && bus.rsp_last_i[c];
      timeout[c] = (state_q[c] == CH_BUSY) && guard_ena_i
                   && (budget_i[c*CntWidth +: CntWidth] != '0)
                   && (timer_q[c] >= budget_i[c*CntWidth +: CntWidth]);
      fault_o[c] = (state_q[c] == CH_FAULT);
      outstanding_o[c*OutW +: OutW] = count_q[c];
    end
  end

  assign bus.req_valid_o = bus.req_valid_i & ~gate;
  assign bus.req_ready_o = bus.req_ready_i & ~gate;
  assign any_fault       = |fault_o;
  assign irq_o           = irq_q;
  assign rst_req_o       = rst_req_q;

  always_comb begin
    rs_d    = rs_q;
    rs_done = 1'b0;
    unique case (rs_q)
      RS_RUN:  if ((ResetOnFault != 0) && any_fault) rs_d = RS_REQ;
      RS_REQ:  if (rst_stat_i) rs_d = RS_WAIT;
      RS_WAIT: if (!rst_stat_i) begin
                 rs_d    = RS_RUN;
                 rs_done = 1'b1;
               end
      default: rs_d = RS_RUN;
    endcase
    clear_ok  = clear_i && (rs_q == RS_RUN);
    rst_req_d = (rs_d != RS_RUN);
    irq_d     = 1'b0;

    for (int c = 0; c < NumCh; c++) begin
      // Accept and effective retire together leave the count unchanged.
      count_d[c] = count_q[c];
      if (accept[c] && !(retire[c] && count_q[c] != '0))
        count_d[c] = count_q[c] + 1'b1;
      else if (!accept[c] && retire[c] && count_q[c] != '0)
        count_d[c] = count_q[c] - 1'b1;

      timer_d[c] = timer_q[c];
      if (!guard_ena_i || retire[c] || (accept[c] && count_q[c] == '0))
        timer_d[c] = '0;
      else if (state_q[c] == CH_FAULT) begin
        if (clear_ok) timer_d[c] = '0;
      end else if (state_q[c] == CH_BUSY && tick && timer_q[c] != TimerMax)
        timer_d[c] = timer_q[c] + 1'b1;

      // A fresh timeout beats clear; a same-cycle retire beats the timeout.
      state_d[c] = (count_d[c] != '0) ? CH_BUSY : CH_IDLE;
      if (state_q[c] == CH_FAULT && !clear_ok) state_d[c] = CH_FAULT;
      if (timeout[c] && !retire[c]) state_d[c] = CH_FAULT;

      if (rs_done) begin
        state_d[c] = CH_IDLE;
        count_d[c] = '0;
        timer_d[c] = '0;
      end
      irq_d = irq_d | (state_d[c] == CH_FAULT);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rs_q      <= RS_RUN;
      presc_q   <= '0;
      irq_q     <= 1'b0;
      rst_req_q <= 1'b0;
      for (int c = 0; c < NumCh; c++) begin
        state_q[c] <= CH_IDLE;
        count_q[c] <= '0;
        timer_q[c] <= '0;
      end
    end else begin
      rs_q      <= rs_d;
      presc_q   <= presc_d;
      irq_q     <= irq_d;
      rst_req_q <= rst_req_d;
      for (int c = 0; c < NumCh; c++) begin
        state_q[c] <= state_d[c];
        count_q[c] <= count_d[c];
        timer_q[c] <= timer_d[c];
      end
    end
  end

`ifdef SLV_GUARD_MC_STAT_EN
  logic [CntWidth-1:0] max_lat_q [NumCh];
  logic [CntWidth-1:0] max_lat_d [NumCh];

  always_comb begin
    for (int c = 0; c < NumCh; c++) begin
      max_lat_d[c] = max_lat_q[c];
      if (retire[c] && count_q[c] != '0 && timer_q[c] > max_lat_q[c])
        max_lat_d[c] = timer_q[c];
      if (clear_ok || rs_done) max_lat_d[c] = '0;
      max_lat_o[c*CntWidth +: CntWidth] = max_lat_q[c];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumCh; c++) max_lat_q[c] <= '0;
    end else begin
      for (int c = 0; c < NumCh; c++) max_lat_q[c] <= max_lat_d[c];
    end
  end
`else
  assign max_lat_o = '0;
`endif
endmodule

// File: doc/slv_guard_mc.md
# slv_guard_mc

Multi-channel transaction timeout guard: next generation of the subordinate guard, generalised from a fixed read/write pair to `NumCh` independent request/response channels. Each channel has per-channel budgets, outstanding-transaction accounting and backpressure at a depth limit, and its own fault state. A global reset-request handshake clears all channels. Sits between an ID-remapped manager port and a subordinate. Request valid/ready is gated on fault; response handshakes are observed only.

## Interface
- `NumCh`, 2: number of monitored channels (≥1).
- `MaxTxns`, 8: max outstanding transactions per channel (≥1).
- `CntWidth`, 10: timer/budget width.
- `PrescalerDiv`, 1: timer tick every `PrescalerDiv` cycles (≥1).
- `ResetOnFault`, 1: 1 = any fault launches reset-request handshake.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `guard_ena_i`  in  1  enables timing and fault detection.
- `req_valid_i`  in  NumCh  upstream request valid.
- `req_ready_o`  out  NumCh  upstream request ready.
- `req_valid_o`  out  NumCh  downstream request valid.
- `req_ready_i`  in  NumCh  downstream request ready.
- `rsp_valid_i`, `rsp_ready_i`, `rsp_last_i`  in  NumCh each  observed response handshake.
- `budget_i`  in  NumCh*CntWidth  per-channel budget in ticks; 0 disables that channel's timeout.
- `clear_i`  in  1  single-cycle pulse; clears faults and irq.
- `irq_o`  out  1  OR of channel faults.
- `fault_o`  out  NumCh  per-channel fault flags.
- `outstanding_o`  out  NumCh*OutW  per-channel count, OutW = $clog2(MaxTxns+1).
- `rst_req_o`  out  1  reset request to subordinate.
- `rst_stat_i`  in  1  subordinate reset status.
- `max_lat_o`  out  NumCh*CntWidth  latency statistic (see Configuration).

## Operation
- Accept on channel c: `req_valid_o[c] && req_ready_i[c]`. Retire: `rsp_valid_i[c] && rsp_ready_i[c] && rsp_last_i[c]`.
- Count: +1 on accept, −1 on retire, unchanged on both. Retire at 0 is ignored; count stays 0.
- Count == MaxTxns: `req_ready_o[c]=0`, `req_valid_o[c]=0`. Pass-through otherwise: `req_valid_o=req_valid_i`, `req_ready_o=req_ready_i`.
- Per-channel states:
  - IDLE (count 0).
  - BUSY (count > 0).
  - FAULT: gates `req_valid_o[c]` and `req_ready_o[c]` to 0. Count tracking continues.
- Prescaler: a free-running counter produces `tick` once every PrescalerDiv cycles. With PrescalerDiv=1, tick is held high.
- Progress timer per channel:
  - Zeroed on retire, on 0→1 count transition, and when `guard_ena_i=0`.
  - Increments on tick while BUSY; saturates at all-ones.
- Timeout: BUSY && `guard_ena_i` && budget≠0 && timer ≥ budget. Next edge enters FAULT.
- `clear_i`: every FAULT channel goes to BUSY or IDLE by count; timer zeroed. Ignored while the reset FSM is not RUN.
- Reset FSM (ResetOnFault=1):
  - RUN → REQ when any fault.
  - REQ: `rst_req_o=1`. → WAIT when `rst_stat_i=1`.
  - WAIT: `rst_req_o=1`. → RUN when `rst_stat_i=0`.
  - On the WAIT→RUN edge: all counts, timers and faults cleared.
- ResetOnFault=0: FSM stays RUN. Faults persist until `clear_i`.

## Timing
- Reset values:
  - All registers 0; states IDLE, FSM RUN.
  - `irq_o=0`, `fault_o=0`, `rst_req_o=0`, `outstanding_o=0`, `max_lat_o=0`.
- Gating of `req_*` is combinational from the state register; there is no datapath latency.
- Timeout timing: timer reaches budget at edge N → FAULT and `irq_o` high after edge N+1.
- `fault_o`, `irq_o`, `rst_req_o` are registered.
- Simultaneous timeout and retire in the same cycle: retire wins; timer zeroed, no fault.
- Simultaneous `clear_i` and new timeout: the new timeout wins; the channel stays FAULT.
- Asynchronous reset mid-transaction drops all state immediately.

## Configuration
- Macro `SLV_GUARD_MC_STAT_EN`.
  - Defined: per channel, `max_lat_o` records the max timer value observed at retire; cleared by `clear_i` and reset-FSM completion.
  - Undefined: the statistic registers are absent and `max_lat_o` is tied to 0.

## Test plan
- NumCh=2, budget0=5, PrescalerDiv=1: accept 1 txn on ch0, no response → `fault_o=01`, `irq_o=1` after 7 cycles; `req_ready_o[0]=0`; ch1 traffic unaffected.
- MaxTxns=8: 8 accepts with no retire → `outstanding_o[0]=8`, `req_ready_o[0]=0`. Then 1 retire → count 7, ready restored.
- ResetOnFault=1: force a fault → `rst_req_o=1`. Pulse `rst_stat_i` high 3 cycles then low → `rst_req_o=0`, all counts 0, `irq_o=0`.
- Boundary and suppression:
  - Retire on the same cycle the timer equals budget → no fault.
  - `budget_i=0` with a 1000-cycle stall → no fault.
  - `guard_ena_i=0` → no fault.
- PrescalerDiv=4, budget=3: stalled txn faults after 13±1 cycles. With ResetOnFault=0, `clear_i` → fault clears; the channel returns to BUSY and re-faults after a further 13±1 cycles.
- STAT_EN: retire latencies of 2, then 6, then 3 ticks → `max_lat_o[0]=6`; `clear_i` → 0.
